xor_gate_exerciser: RTL and testbench

- Self-checking stimulus and response stage that sits directly upstream of an XOR gate under test (dataflow, behavioural or structural variant) and consumes the gate's output.
- Sweeps every input combination in binary order and holds each one for a programmable number of cycles.
- Samples the gate output, compares it against expected parity and reports pass/fail plus an error count.
- Replaces the hand-written 0/0, 0/1, 1/0, 1/1 stimulus sequences with a reusable clocked block.

---
 rtl/xor_exerciser_pkg.sv | 21 ++
 rtl/exerciser_hold_timer.sv | 49 ++++
 rtl/xor_gate_exerciser.sv | 195 +++++++++++++++++++
 tb/tb_xor_gate_exerciser.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_exerciser_pkg.sv
// Shared types for the XOR gate exerciser: sweep FSM state encoding and parameter defaults.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package xor_exerciser_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default error counter width.
  localparam int ERR_W_DEFAULT       = 8;
  // Default number of gate inputs swept.
  localparam int N_IN_DEFAULT        = 2;
  // Default cycles each vector is held before the response is sampled.
  localparam int HOLD_CYCLES_DEFAULT = 10;

endpackage

// File: rtl/exerciser_hold_timer.sv
// Hold timer: counts cycles a stimulus vector has been applied; flags HOLD_CYCLES-1 as terminal count.
// Latency: tc reflects the registered count (same cycle as the count value).
// Backpressure: none; clr wins over inc, count holds when neither is asserted.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear of the count to zero
//   inc        : advance the count by one
//   tc         : high while the count equals HOLD_CYCLES-1
module exerciser_hold_timer
  import xor_exerciser_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  // HOLD_CYCLES >= 2, so the count width is always at least one bit.
  localparam int            CW      = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] TC_VAL  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/xor_gate_exerciser.sv
// XOR gate exerciser: sweeps all N_IN-bit vectors in binary order, holds each, checks the
// gate response against parity and reports pass/fail, error count and first failing vector.
// Latency: done pulses 2^N_IN*(HOLD_CYCLES+1)+1 cycles after start is accepted; start is
// ignored while a sweep is running (only sampled in IDLE).
//
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : begin a sweep (pulse or level, sampled only in IDLE)
//   stim         : vector driven to the gate inputs (bit 0 = a, bit 1 = b)
//   resp         : gate output, may be combinational from stim
//   busy         : sweep in progress
//   done         : one-cycle pulse at the end of a sweep
//   pass         : zero mismatches in the last sweep (valid with sweep_valid)
//   sweep_valid  : result outputs hold a completed sweep
//   err_count    : mismatching vectors, saturating at all-ones
//   fail_vec     : first mismatching vector, zero if none
//
// Build option: defining XOR_EXERCISER_STOP_ON_FAIL_EN ends the sweep at the first
// mismatching vector and leaves stim on that vector.
module xor_gate_exerciser
  import xor_exerciser_pkg::*;
#(
  parameter int N_IN        = N_IN_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int ERR_W       = ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             sweep_valid,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  fail_vec
);

  localparam logic [N_IN-1:0]  STIM_ONE = N_IN'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [N_IN-1:0]  stim_q;
  logic [N_IN-1:0]  stim_d;
  logic [N_IN-1:0]  fail_vec_q;
  logic [N_IN-1:0]  fail_vec_d;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic             resp_q;
  logic             resp_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             pass_q;
  logic             pass_d;
  logic             sweep_valid_q;
  logic             sweep_valid_d;

  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_tc;

  logic             expected;
  logic             mismatch;
  logic             last_vec;
  logic             end_sweep;

  exerciser_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .tc    (tmr_tc)
  );

  // A correct XOR gate outputs the parity of its inputs.
  assign expected = ^stim_q;
  assign mismatch = (resp_q != expected);
  assign last_vec = (stim_q == '1);

`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
  // Any mismatch seen in CHECK is the first one, since the sweep stops there.
  assign end_sweep = last_vec || mismatch;
`else
  assign end_sweep = last_vec;
`endif

  always_comb begin
    state_d       = state_q;
    stim_d        = stim_q;
    fail_vec_d    = fail_vec_q;
    err_count_d   = err_count_q;
    resp_d        = resp_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    sweep_valid_d = sweep_valid_q;
    tmr_clr       = 1'b0;
    tmr_inc       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = DRIVE;
          stim_d        = '0;
          err_count_d   = '0;
          fail_vec_d    = '0;
          sweep_valid_d = 1'b0;
          busy_d        = 1'b1;
          tmr_clr       = 1'b1;
        end
      end

      DRIVE: begin
        // The gate has had HOLD_CYCLES-1 full cycles to settle when tc is reached.
        if (tmr_tc) begin
          resp_d  = resp;
          state_d = CHECK;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      CHECK: begin
        if (mismatch) begin
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_ONE;
          end
          // A zero count means nothing has failed yet in this sweep.
          if (err_count_q == '0) begin
            fail_vec_d = stim_q;
          end
        end
        if (end_sweep) begin
          state_d = DONE;
        end else begin
          stim_d  = stim_q + STIM_ONE;
          tmr_clr = 1'b1;
          state_d = DRIVE;
        end
      end

      DONE: begin
        // err_count_q already includes the final vector's CHECK update.
        done_d        = 1'b1;
        busy_d        = 1'b0;
        sweep_valid_d = 1'b1;
        pass_d        = (err_count_q == '0);
        state_d       = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      stim_q        <= '0;
      fail_vec_q    <= '0;
      err_count_q   <= '0;
      resp_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      sweep_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stim_q        <= stim_d;
      fail_vec_q    <= fail_vec_d;
      err_count_q   <= err_count_d;
      resp_q        <= resp_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      sweep_valid_q <= sweep_valid_d;
    end
  end

  assign stim        = stim_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign sweep_valid = sweep_valid_q;
  assign err_count   = err_count_q;
  assign fail_vec    = fail_vec_q;

endmodule

// File: tb/tb_xor_gate_exerciser.sv
// Bench for xor_gate_exerciser: a timeline model of the 2-input, hold-10 exerciser compared
// every cycle, plus literal checks on known gates, a 3-input saturating instance and a
// 1-input instance.
module tb_xor_gate_exerciser;

  localparam int MH = 10;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] stim;
    logic [7:0] err;
    logic [1:0] fail;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // Main instance: N_IN=2, HOLD_CYCLES=10, gate behaviour from a truth table.
  logic       start   = 1'b0;
  logic [3:0] gate_tt = 4'b0110;
  logic [1:0] stim;
  logic       resp;
  logic       busy, done, pass, sweep_valid;
  logic [7:0] err_count;
  logic [1:0] fail_vec;

  // Saturation instance: N_IN=3, HOLD_CYCLES=3, ERR_W=2, gate stuck at 0.
  logic       start_s = 1'b0;
  logic [2:0] stim_s;
  logic       busy_s, done_s, pass_s, sv_s;
  logic [1:0] err_s;
  logic [2:0] fail_s;

  // Single-input instance: N_IN=1, HOLD_CYCLES=2, gate is a buffer optionally inverted.
  logic       start_1 = 1'b0;
  logic       inv_1   = 1'b0;
  logic [0:0] stim_1;
  logic       resp_1;
  logic       busy_1, done_1, pass_1, sv_1;
  logic [3:0] err_1;
  logic [0:0] fail_1;

  assign resp   = gate_tt[stim];
  assign resp_1 = stim_1[0] ^ inv_1;

  xor_gate_exerciser #(.N_IN(2), .HOLD_CYCLES(MH), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp),
    .busy(busy), .done(done), .pass(pass), .sweep_valid(sweep_valid),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  xor_gate_exerciser #(.N_IN(3), .HOLD_CYCLES(3), .ERR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stim(stim_s), .resp(1'b0),
    .busy(busy_s), .done(done_s), .pass(pass_s), .sweep_valid(sv_s),
    .err_count(err_s), .fail_vec(fail_s)
  );

  xor_gate_exerciser #(.N_IN(1), .HOLD_CYCLES(2), .ERR_W(4)) dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .stim(stim_1), .resp(resp_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .sweep_valid(sv_1),
    .err_count(err_1), .fail_vec(fail_1)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_mis  = 0;
  int cyc    = 0;
  int t_acc  = 0;
  int dn_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs of the main instance 'off' edges after the accepting edge, derived
  // from the sweep timeline: each vector occupies MH+1 cycles, its result lands at the
  // edge that starts the next vector, DONE follows the last vector, done one edge later.
  function automatic exp_t predict(input logic [3:0] tt, input int off);
    exp_t e;
    int   nrun, len, k, chkd, cnt, fv;
    nrun = 4;
`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
    for (int v = 3; v >= 0; v--)
      if (tt[v] != ($countones(v) % 2 == 1)) nrun = v + 1;
`endif
    len  = nrun * (MH + 1);
    k    = off / (MH + 1);
    chkd = (k < nrun) ? k : nrun;
    cnt  = 0;
    fv   = 0;
    for (int v = 0; v < chkd; v++) begin
      if (tt[v] != ($countones(v) % 2 == 1)) begin
        if (cnt == 0) fv = v;
        cnt++;
      end
    end
    e.busy = (off <= len);
    e.done = (off == len + 1);
    e.stim = 2'((k < nrun - 1) ? k : nrun - 1);
    e.err  = 8'((cnt > 255) ? 255 : cnt);
    e.fail = 2'(fv);
    return e;
  endfunction

  logic       m_idle = 1'b1;
  int         m_T    = 0;
  logic [3:0] m_tt   = 4'b0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_sv = 1'b0, m_pass = 1'b0;
  logic [1:0] m_stim = 2'b0, m_fail = 2'b0;
  logic [7:0] m_err  = 8'b0;
  exp_t       p_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0; m_sv <= 1'b0; m_pass <= 1'b0;
      m_stim <= 2'b0; m_err <= 8'b0; m_fail <= 2'b0;
    end else begin
      cyc    <= cyc + 1;
      m_done <= 1'b0;
      if (m_idle && start) begin
        m_idle <= 1'b0; m_T <= cyc; m_tt <= gate_tt;
        m_busy <= 1'b1; m_stim <= 2'b0; m_err <= 8'b0; m_fail <= 2'b0; m_sv <= 1'b0;
      end else if (!m_idle) begin
        p_m = predict(m_tt, cyc - m_T);
        m_busy <= p_m.busy; m_stim <= p_m.stim; m_err <= p_m.err; m_fail <= p_m.fail;
        if (p_m.done) begin
          m_done <= 1'b1; m_sv <= 1'b1; m_pass <= (p_m.err == 8'd0); m_idle <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("sweep_valid", int'(sweep_valid), int'(m_sv));
    chk("stim", int'(stim), int'(m_stim));
    chk("err_count", int'(err_count), int'(m_err));
    chk("fail_vec", int'(fail_vec), int'(m_fail));
    if (m_sv) chk("pass", int'(pass), int'(m_pass));
    if (done) dn_cnt++;
  end

  task automatic pulse_main();
    @(negedge clk);
    start = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, output int lat);
    int found;
    found = 0;
    lat   = -1;
    for (int i = 0; i < budget && found == 0; i++) begin
      @(negedge clk);
      #3;
      if ((which == 0 && done) || (which == 1 && done_s) || (which == 2 && done_1)) begin
        found = 1;
        lat   = cyc - 1 - t_acc;
      end
    end
    chk("done_seen", found, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dn0;
    int reached;

    // Reset state.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_stim", int'(stim), 0);
    chk("rst_sv", int'(sweep_valid), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known-good gate, with an extra start pulse while busy.
    gate_tt = 4'b0110;
    dn0 = dn_cnt;
    pulse_main();
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 200, lat);
    chk("xor_latency", lat, 45);
    chk("xor_err", int'(err_count), 0);
    chk("xor_pass", int'(pass), 1);
    chk("xor_fail_vec", int'(fail_vec), 0);
    chk("xor_sv", int'(sweep_valid), 1);
    chk("xor_stim_last", int'(stim), 3);
    repeat (20) @(negedge clk);
    chk("xor_single_done", dn_cnt - dn0, 1);

    // Stuck-at-0 gate.
    gate_tt = 4'b0000;
    pulse_main();
    wait_done(0, 200, lat);
`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
    chk("sa0_latency", lat, 23);
    chk("sa0_err", int'(err_count), 1);
    chk("sa0_stim_held", int'(stim), 1);
`else
    chk("sa0_latency", lat, 45);
    chk("sa0_err", int'(err_count), 2);
    chk("sa0_stim_last", int'(stim), 3);
`endif
    chk("sa0_fail_vec", int'(fail_vec), 1);
    chk("sa0_pass", int'(pass), 0);

    // XNOR gate.
    gate_tt = 4'b1001;
    pulse_main();
    wait_done(0, 200, lat);
`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
    chk("xnor_latency", lat, 12);
    chk("xnor_err", int'(err_count), 1);
`else
    chk("xnor_latency", lat, 45);
    chk("xnor_err", int'(err_count), 4);
`endif
    chk("xnor_fail_vec", int'(fail_vec), 0);
    chk("xnor_pass", int'(pass), 0);

    // Reset during vector 10 with a failure already recorded, then a clean sweep.
`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
    gate_tt = 4'b0110;
`else
    gate_tt = 4'b0000;
`endif
    pulse_main();
    reached = 0;
    for (int i = 0; i < 100 && reached == 0; i++) begin
      @(negedge clk);
      #3;
      if (stim == 2'b10) reached = 1;
    end
    chk("rst_mid_reached_vec10", reached, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_stim", int'(stim), 0);
    chk("rst_mid_err", int'(err_count), 0);
    chk("rst_mid_fail_vec", int'(fail_vec), 0);
    chk("rst_mid_sv", int'(sweep_valid), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    gate_tt = 4'b0110;
    pulse_main();
    wait_done(0, 200, lat);
    chk("rst_clean_pass", int'(pass), 1);
    chk("rst_clean_err", int'(err_count), 0);

    // Start held high: second sweep accepted the edge after done.
    @(negedge clk);
    start = 1'b1;
    t_acc = cyc;
    wait_done(0, 200, lat);
    chk("held_latency", lat, 45);
    chk("held_done_busy", int'(busy), 0);
    @(negedge clk);
    #3;
    chk("held_restart_busy", int'(busy), 1);
    chk("held_restart_sv", int'(sweep_valid), 0);
    start = 1'b0;
    wait_done(0, 200, lat);
    chk("held_second_latency", lat, 91);

    // Random start activity and random gate truth tables.
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      #3;
      if (done) gate_tt = 4'($urandom);
    end
    start = 1'b0;

    // Saturation: 3-input sweep against a stuck-at-0 gate.
    @(negedge clk);
    start_s = 1'b1;
    t_acc   = cyc;
    @(negedge clk);
    start_s = 1'b0;
    wait_done(1, 100, lat);
`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
    chk("sat_latency", lat, 9);
    chk("sat_err", int'(err_s), 1);
    chk("sat_stim_held", int'(stim_s), 1);
`else
    chk("sat_latency", lat, 33);
    chk("sat_err", int'(err_s), 3);
    chk("sat_stim_last", int'(stim_s), 7);
`endif
    chk("sat_fail_vec", int'(fail_s), 1);
    chk("sat_pass", int'(pass_s), 0);
    chk("sat_sv", int'(sv_s), 1);

    // Single-input instance: correct buffer, then inverted.
    @(negedge clk);
    start_1 = 1'b1;
    t_acc   = cyc;
    @(negedge clk);
    start_1 = 1'b0;
    wait_done(2, 50, lat);
    chk("n1_latency", lat, 7);
    chk("n1_pass", int'(pass_1), 1);
    chk("n1_err", int'(err_1), 0);
    chk("n1_stim_last", int'(stim_1), 1);
    inv_1 = 1'b1;
    @(negedge clk);
    start_1 = 1'b1;
    t_acc   = cyc;
    @(negedge clk);
    start_1 = 1'b0;
    wait_done(2, 50, lat);
`ifdef XOR_EXERCISER_STOP_ON_FAIL_EN
    chk("n1_inv_latency", lat, 4);
    chk("n1_inv_err", int'(err_1), 1);
`else
    chk("n1_inv_latency", lat, 7);
    chk("n1_inv_err", int'(err_1), 2);
`endif
    chk("n1_inv_fail_vec", int'(fail_1), 0);
    chk("n1_inv_pass", int'(pass_1), 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
